sap1_controller: RTL and testbench
==================================

Name: sap1_controller

Overview:
- Controller-sequencer for the SAP-1 datapath; it is the initiator side of the register load/enable interface that registradorB and its sibling registers respond to.
- A 6-state one-hot ring counter (T1..T6) combined with the opcode from the upper nibble of the IR drives every load and enable line on the bus: Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo.
- Handles halt (HLT) and undefined opcodes (executed as NOP).

Parameters:
- RING_LEN, 6, number of T states; must be >= 6. States beyond T6 emit no control lines.
- OPCODE_W, 4, opcode width.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- CLR  input  1  synchronous, active-high reset.
- opcode  input  OPCODE_W  IR upper nibble; sampled combinationally, valid from T4 onward.
- Cp  output  1  PC increment.
- Ep  output  1  PC drives the bus.
- Lm  output  1  MAR load.
- CE  output  1  RAM drives the bus.
- Li  output  1  IR load.
- Ei  output  1  IR operand nibble drives the bus.
- La  output  1  accumulator load.
- Ea  output  1  accumulator drives the bus.
- Su  output  1  ALU subtract select.
- Eu  output  1  ALU drives the bus.
- Lb  output  1  B register load.
- Lo  output  1  output register load.
- HLT  output  1  halt indicator.
- t_state  output  RING_LEN  one-hot current T state.

Behaviour:
- All control lines are active-high.
- Control outputs are a combinational decode of the registered t_state, the halted flag, and opcode.

Opcodes:
- LDA = 0000, ADD = 0001, SUB = 0010, OUT = 1110, HLT = 1111.
- All other opcodes are NOP.

Fetch cycle (every instruction):
- T1: Ep, Lm.
- T2: Cp.
- T3: CE, Li.

Execute cycle:
- LDA: T4 Ei, Lm; T5 CE, La; T6 none.
- ADD: T4 Ei, Lm; T5 CE, Lb; T6 Eu, La.
- SUB: same as ADD, with Su also asserted in T5 and T6.
- OUT: T4 Ea, Lo; T5 and T6 none.
- NOP: T4..T6 none.

Ring counter:
- Advances one position per clock.
- Wraps from T[RING_LEN] back to T1, so each instruction takes exactly RING_LEN cycles.
- t_state is always exactly one-hot. If an illegal state is ever detected, the next state is T1.

Halt:
- In T4 with opcode HLT, the HLT output is 1 and no other controls are asserted.
- At that edge the halted flag is set and t_state freezes at T4.
- While halted: HLT = 1, all other controls = 0, t_state is held.
- Only CLR exits the halted state.

Reset:
- While CLR = 1, all control outputs and HLT are forced to 0.
- At the edge with CLR = 1: t_state <= one-hot T1 (bit0 = 1), halted <= 0.
- Outputs become the T1 decode in the first cycle after CLR is released.
- CLR takes priority over halt entry and over ring advance, including CLR asserted mid-instruction.

Opcode timing:
- Opcode changes during T1..T3 are don't-care and must not affect outputs, because fetch decode ignores opcode.

Optional Feature:
- Macro: SAP1_SINGLE_STEP_EN.
- When defined: adds input port STEP (1 bit).
  - The ring counter and halt entry update only on edges where STEP = 1.
  - With STEP = 0, t_state and halted hold and the outputs keep decoding the current state.
  - CLR still acts regardless of STEP.
- When not defined: no STEP port; the ring counter advances every clock.

Decomposition:
- Package sap1_pkg holds:
  - opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT;
  - the T-state index constants T1..T6;
  - a packed control-word typedef ctrl_word_t with fields Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo HLT.
- One natural sub-module: sap1_ring_counter (one-hot ring with CLR, hold enable, and illegal-state recovery).
- The decode stays in sap1_controller.

Test Plan:
- CLR held 2 cycles, then released with opcode = 0000 -> t_state = 000001; during CLR all outputs = 0; first cycle after release Ep = Lm = 1; Cp = 1 next cycle; CE = Li = 1 the cycle after.
- opcode = 0001 (ADD) -> T4 {Ei, Lm}, T5 {CE, Lb}, T6 {Eu, La}, Su = 0 throughout; t_state returns to 000001 at cycle 7.
- opcode = 0010 (SUB) -> identical to ADD with Su = 1 in T5 and T6.
- opcode = 1110 then 0101 on consecutive instructions -> OUT gives T4 {Ea, Lo}; opcode 0101 gives no controls in T4..T6.
- opcode = 1111 -> HLT = 1 from T4; t_state stays 001000 for 20 cycles with all other outputs 0; CLR pulse restores T1 and HLT = 0.
- CLR asserted at T5 of LDA -> next cycle t_state = 000001, no La pulse completes; with SAP1_SINGLE_STEP_EN defined, STEP = 0 for 5 cycles holds t_state and STEP pulses advance it one state each.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared types and constants for the SAP-1 controller-sequencer.
// The optional single-step feature is enabled with the SAP1_SINGLE_STEP_EN macro.
package sap1_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_LDA = 4'b0000;
    localparam opcode_t OP_ADD = 4'b0001;
    localparam opcode_t OP_SUB = 4'b0010;
    localparam opcode_t OP_OUT = 4'b1110;
    localparam opcode_t OP_HLT = 4'b1111;

    // Bit positions of each T state inside the one-hot ring.
    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    typedef struct packed {
        logic Cp;
        logic Ep;
        logic Lm;
        logic CE;
        logic Li;
        logic Ei;
        logic La;
        logic Ea;
        logic Su;
        logic Eu;
        logic Lb;
        logic Lo;
        logic HLT;
    } ctrl_word_t;

    typedef enum logic {
        RUN_S  = 1'b0,
        HALT_S = 1'b1
    } run_state_e;

endpackage

// File: rtl/sap1_controller_if.sv
// Control bus between the SAP-1 sequencer (master) and the datapath registers (slave).
// Also carries the opcode back from the IR and the current one-hot T state.
interface sap1_controller_if #(
    parameter int RING_LEN = 6,
    parameter int OPCODE_W = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic                Cp;
    logic                Ep;
    logic                Lm;
    logic                CE;
    logic                Li;
    logic                Ei;
    logic                La;
    logic                Ea;
    logic                Su;
    logic                Eu;
    logic                Lb;
    logic                Lo;
    logic                HLT;
    logic [RING_LEN-1:0] t_state;

    modport master (
        input  opcode,
        output Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, HLT, t_state
    );

    modport slave (
        output opcode,
        input  Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, HLT, t_state
    );
endinterface

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring with synchronous clear, advance enable and recovery
// to T1 from any non-one-hot value.
module sap1_ring_counter #(
    parameter int RING_LEN = 6
) (
    input  logic                clk_i,
    input  logic                clr_i,
    input  logic                adv_i,
    output logic [RING_LEN-1:0] t_state_o
);

    logic [RING_LEN-1:0] t_state_q;
    logic [RING_LEN-1:0] t_state_d;
    logic                legal;

    assign legal = (t_state_q != '0) && ((t_state_q & (t_state_q - RING_LEN'(1))) == '0);

    always_comb begin
        t_state_d = t_state_q;
        if (!legal) begin
            t_state_d = RING_LEN'(1);
        end else if (adv_i) begin
            t_state_d = {t_state_q[RING_LEN-2:0], t_state_q[RING_LEN-1]};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            t_state_q <= RING_LEN'(1);
        end else begin
            t_state_q <= t_state_d;
        end
    end

    assign t_state_o = t_state_q;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: one-hot ring plus opcode decode driving the control bus.
// Define SAP1_SINGLE_STEP_EN to add a STEP input that gates ring advance and halt entry.
module sap1_controller
    import sap1_pkg::*;
#(
    parameter int RING_LEN = 6,
    parameter int OPCODE_W = 4
) (
    input  logic                     CLK,
    input  logic                     CLR,
`ifdef SAP1_SINGLE_STEP_EN
    input  logic                     STEP,
`endif
    sap1_controller_if.master        bus
);

    logic [RING_LEN-1:0] t_state_q;
    logic [5:0]          t_hit;
    logic                step_en;
    logic                hlt_op;
    logic                halt_entry;
    logic                ring_adv;
    run_state_e          run_q;
    ctrl_word_t          ctrl;

`ifdef SAP1_SINGLE_STEP_EN
    assign step_en = STEP;
`else
    assign step_en = 1'b1;
`endif

    // Exact-match decode so a corrupted (multi-hot) ring drives nothing.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            t_hit[k] = (t_state_q == (RING_LEN'(1) << k));
        end
    end

    assign hlt_op     = (bus.opcode == OP_HLT);
    assign halt_entry = step_en && (run_q == RUN_S) && t_hit[T4] && hlt_op;
    assign ring_adv   = step_en && (run_q == RUN_S) && !(t_hit[T4] && hlt_op);

    sap1_ring_counter #(
        .RING_LEN (RING_LEN)
    ) u_ring (
        .clk_i     (CLK),
        .clr_i     (CLR),
        .adv_i     (ring_adv),
        .t_state_o (t_state_q)
    );

    // Halted flag: only CLR leaves HALT_S.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            run_q <= RUN_S;
        end else if (halt_entry) begin
            run_q <= HALT_S;
        end
    end

    // NOTE: every field gets a default before the case logic, otherwise an
    // unassigned path infers a latch.
    always_comb begin
        ctrl = '0;
        if (!CLR) begin
            if (run_q == HALT_S) begin
                ctrl.HLT = 1'b1;
            end else if (t_hit[T1]) begin
                ctrl.Ep = 1'b1;
                ctrl.Lm = 1'b1;
            end else if (t_hit[T2]) begin
                ctrl.Cp = 1'b1;
            end else if (t_hit[T3]) begin
                ctrl.CE = 1'b1;
                ctrl.Li = 1'b1;
            end else if (t_hit[T4]) begin
                unique case (bus.opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        ctrl.Ei = 1'b1;
                        ctrl.Lm = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl.Ea = 1'b1;
                        ctrl.Lo = 1'b1;
                    end
                    OP_HLT:  ctrl.HLT = 1'b1;
                    default: ;
                endcase
            end else if (t_hit[T5]) begin
                unique case (bus.opcode)
                    OP_LDA: begin
                        ctrl.CE = 1'b1;
                        ctrl.La = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.CE = 1'b1;
                        ctrl.Lb = 1'b1;
                        ctrl.Su = (bus.opcode == OP_SUB);
                    end
                    default: ;
                endcase
            end else if (t_hit[T6]) begin
                if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                    ctrl.Eu = 1'b1;
                    ctrl.La = 1'b1;
                    ctrl.Su = (bus.opcode == OP_SUB);
                end
            end
        end
    end

    assign bus.Cp      = ctrl.Cp;
    assign bus.Ep      = ctrl.Ep;
    assign bus.Lm      = ctrl.Lm;
    assign bus.CE      = ctrl.CE;
    assign bus.Li      = ctrl.Li;
    assign bus.Ei      = ctrl.Ei;
    assign bus.La      = ctrl.La;
    assign bus.Ea      = ctrl.Ea;
    assign bus.Su      = ctrl.Su;
    assign bus.Eu      = ctrl.Eu;
    assign bus.Lb      = ctrl.Lb;
    assign bus.Lo      = ctrl.Lo;
    assign bus.HLT     = ctrl.HLT;
    assign bus.t_state = t_state_q;

endmodule

// File: tb/tb_sap1_controller.sv
// Self-checking bench for sap1_controller against an instruction-level model
// that tracks the cycle index inside the current instruction and a halted bit.
module tb_sap1_controller;
    import sap1_pkg::*;

    localparam int RING_LEN = 6;
    localparam int OPCODE_W = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       step = 1'b1;
    logic [3:0] op = 4'h0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which cycle of the instruction we are in, and halted.
    int m_phase  = 0;
    bit m_halted = 1'b0;

    sap1_controller_if #(.RING_LEN(RING_LEN), .OPCODE_W(OPCODE_W)) bus ();
    assign bus.opcode = op;

    sap1_controller #(
        .RING_LEN (RING_LEN),
        .OPCODE_W (OPCODE_W)
    ) dut (
        .CLK  (clk),
        .CLR  (clr),
`ifdef SAP1_SINGLE_STEP_EN
        .STEP (step),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Control lines required in cycle `phase` of an instruction with opcode `o`.
    function automatic ctrl_word_t expect_ctrl(int phase, logic [3:0] o, bit halted, logic reset);
        ctrl_word_t e;
        e = '0;
        if (reset) return e;
        if (halted) begin
            e.HLT = 1'b1;
            return e;
        end
        case (phase)
            0: begin e.Ep = 1; e.Lm = 1; end
            1: e.Cp = 1;
            2: begin e.CE = 1; e.Li = 1; end
            3: begin
                if (o == OP_LDA || o == OP_ADD || o == OP_SUB) begin e.Ei = 1; e.Lm = 1; end
                else if (o == OP_OUT) begin e.Ea = 1; e.Lo = 1; end
                else if (o == OP_HLT) e.HLT = 1;
            end
            4: begin
                if (o == OP_LDA) begin e.CE = 1; e.La = 1; end
                else if (o == OP_ADD || o == OP_SUB) begin e.CE = 1; e.Lb = 1; e.Su = (o == OP_SUB); end
            end
            5: begin
                if (o == OP_ADD || o == OP_SUB) begin e.Eu = 1; e.La = 1; e.Su = (o == OP_SUB); end
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_now(input string name);
        ctrl_word_t got;
        ctrl_word_t exp;
        logic [RING_LEN-1:0] exp_t;
        got.Cp = bus.Cp;  got.Ep = bus.Ep;  got.Lm = bus.Lm;  got.CE = bus.CE;
        got.Li = bus.Li;  got.Ei = bus.Ei;  got.La = bus.La;  got.Ea = bus.Ea;
        got.Su = bus.Su;  got.Eu = bus.Eu;  got.Lb = bus.Lb;  got.Lo = bus.Lo;
        got.HLT = bus.HLT;
        exp   = expect_ctrl(m_phase, op, m_halted, clr);
        exp_t = RING_LEN'(1) << m_phase;
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s ctrl (T%0d op=%b): got %b required %b [Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo HLT]",
                     name, m_phase + 1, op, got, exp);
        end
        n_checks++;
        if (bus.t_state !== exp_t) begin
            n_errors++;
            $display("FAIL %s t_state: got %b required %b", name, bus.t_state, exp_t);
        end
    endtask

    task automatic model_edge();
        if (clr) begin
            m_phase  = 0;
            m_halted = 1'b0;
        end else if (step && !m_halted) begin
            if (m_phase == 3 && op == OP_HLT) m_halted = 1'b1;
            else m_phase = (m_phase + 1) % RING_LEN;
        end
    endtask

    // One clock: drive opcode (random while it is a don't-care), check, clock the model.
    task automatic cycle(input string name, input logic [3:0] instr_op, input bit rand_fetch);
        if (rand_fetch && (m_halted || m_phase < 3)) op = 4'($urandom_range(0, 15));
        else op = instr_op;
        #1;
        check_now(name);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run_instr(input string name, input logic [3:0] instr_op);
        repeat (RING_LEN) cycle(name, instr_op, 1'b1);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        op  = 4'b0000;
        repeat (2) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            #1;
            check_now("reset_held");
        end
        clr = 1'b0;
        repeat (RING_LEN) cycle("reset_release", 4'b0000, 1'b0);
    endtask

    task automatic test_instrs();
        run_instr("add", OP_ADD);
        run_instr("sub", OP_SUB);
        run_instr("out", OP_OUT);
        run_instr("nop_0101", 4'b0101);
        run_instr("lda", OP_LDA);
    endtask

    task automatic test_random();
        logic [3:0] r;
        for (int i = 0; i < 40; i++) begin
            r = 4'($urandom_range(0, 14));
            run_instr("random", r);
        end
    endtask

    task automatic test_clr_mid();
        repeat (4) cycle("clr_mid_pre", OP_LDA, 1'b1);
        clr = 1'b1;
        cycle("clr_mid_t5", OP_LDA, 1'b0);
        clr = 1'b0;
        run_instr("clr_mid_after", OP_LDA);
    endtask

    task automatic test_halt();
        repeat (4) cycle("halt_entry", OP_HLT, 1'b1);
        repeat (20) cycle("halted", OP_HLT, 1'b1);
        clr = 1'b1;
        cycle("halt_clr", OP_HLT, 1'b0);
        clr = 1'b0;
        run_instr("after_halt", OP_ADD);
    endtask

`ifdef SAP1_SINGLE_STEP_EN
    task automatic test_single_step();
        repeat (2) cycle("step_run", OP_SUB, 1'b1);
        step = 1'b0;
        repeat (5) cycle("step_hold", OP_SUB, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step = 1'b1;
            cycle("step_pulse", (i < 4) ? OP_SUB : OP_HLT, 1'b1);
            step = 1'b0;
            repeat (2) cycle("step_gap", (i < 4) ? OP_SUB : OP_HLT, 1'b1);
        end
        step = 1'b1;
        clr  = 1'b1;
        cycle("step_clr", OP_LDA, 1'b0);
        clr  = 1'b0;
        run_instr("step_after", OP_LDA);
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_instrs();
        test_random();
        test_clr_mid();
        test_halt();
`ifdef SAP1_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
